// File: rtl/rising_edge_pkg.sv
// Shared constants for the rising-edge detector: parameter limits and counter width.
package rising_edge_pkg;

  localparam int unsigned MAX_WIDTH       = 64;
  localparam int unsigned MAX_SYNC_STAGES = 3;
  localparam int unsigned COUNT_W         = 16;

endpackage

// File: rtl/edge_sync.sv
// WIDTH x SYNC_STAGES synchronizer chain with async active-low clear.
// SYNC_STAGES=0 makes it a plain wire.
module edge_sync #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] s
);

  if (SYNC_STAGES == 0) begin : g_bypass
    // Already synchronous: clock and reset are intentionally not used.
    logic unused_ctrl;
    assign unused_ctrl = clock | reset;
    assign s = d_in;
  end else begin : g_chain
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        stage_q <= '0;
      end else begin
        stage_q[0] <= d_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign s = stage_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/rising_edge.sv
// Per-lane synchronous rising-edge detector with optional input synchronizer.
// Define RISING_EDGE_COUNT_EN to add the edge_count output (cycles with any pulse).
module rising_edge
  import rising_edge_pkg::*;
#(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned SYNC_STAGES    = 0,
  parameter int unsigned REGISTERED_OUT = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   d_in,
  output logic [WIDTH-1:0]   y
`ifdef RISING_EDGE_COUNT_EN
  ,
  output logic [COUNT_W-1:0] edge_count
`endif
);

  if (WIDTH == 0 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("rising_edge: WIDTH out of range");
  end
  if (SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("rising_edge: SYNC_STAGES out of range");
  end

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] e;

  edge_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d_in (d_in),
    .s    (s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_q <= '0;
    end else begin
      d_q <= s;
    end
  end

  assign e = s & ~d_q;

  if (REGISTERED_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] y_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        y_q <= '0;
      end else begin
        y_q <= e;
      end
    end

    assign y = y_q;
  end else begin : g_comb_out
    logic [WIDTH-1:0] d_q2;
    logic             unused_e;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        d_q2 <= '0;
      end else begin
        d_q2 <= d_q;
      end
    end

    // Built only from flops, so glitch-free and timed exactly like the registered form.
    assign y        = d_q & ~d_q2;
    assign unused_e = ^e;
  end

`ifdef RISING_EDGE_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  // e at an edge is exactly what y shows after that edge in either output mode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (|e) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign edge_count = count_q;
`endif

endmodule

// File: tb/tb_rising_edge.sv
// Directed bench for rising_edge: registered and combinational output variants (4 lanes)
// plus a 2-stage synchronizer variant on lane 0; counter checks when RISING_EDGE_COUNT_EN.
module tb_rising_edge;

  logic       clock;
  logic       reset;
  logic [3:0] d4;
  logic [3:0] y_a;
  logic [3:0] y_c;
  logic [0:0] y_b;
  logic [0:0] d_b;

  int total = 0;
  int bad   = 0;

`ifdef RISING_EDGE_COUNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
  logic [15:0] cnt_c;
`endif

  assign d_b = d4[0:0];

  rising_edge #(.WIDTH(4), .SYNC_STAGES(0), .REGISTERED_OUT(1)) dut_a (
    .clock(clock),
    .reset(reset),
    .d_in (d4),
    .y    (y_a)
`ifdef RISING_EDGE_COUNT_EN
    ,
    .edge_count(cnt_a)
`endif
  );

  rising_edge #(.WIDTH(1), .SYNC_STAGES(2), .REGISTERED_OUT(1)) dut_b (
    .clock(clock),
    .reset(reset),
    .d_in (d_b),
    .y    (y_b)
`ifdef RISING_EDGE_COUNT_EN
    ,
    .edge_count(cnt_b)
`endif
  );

  rising_edge #(.WIDTH(4), .SYNC_STAGES(0), .REGISTERED_OUT(0)) dut_c (
    .clock(clock),
    .reset(reset),
    .d_in (d4),
    .y    (y_c)
`ifdef RISING_EDGE_COUNT_EN
    ,
    .edge_count(cnt_c)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive d, clock once, then check both 4-lane variants against the same expectation.
  task automatic cycle(input logic [3:0] d, input logic [3:0] exp, input string tag);
    d4 = d;
    tick();
    check_eq({tag, "_reg"}, 64'(y_a), 64'(exp));
    check_eq({tag, "_comb"}, 64'(y_c), 64'(exp));
  endtask

  initial begin
    reset = 1'b0;
    d4    = 4'b0000;

    // Reset held with input toggling: no pulses anywhere.
    for (int i = 0; i < 3; i++) begin
      d4 = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
      check_eq("rst_hold_a", 64'(y_a), 64'd0);
      check_eq("rst_hold_b", 64'(y_b), 64'd0);
      check_eq("rst_hold_c", 64'(y_c), 64'd0);
    end
    d4    = 4'b0000;
    reset = 1'b1;
    cycle(4'b0000, 4'b0000, "rel_low0");
    cycle(4'b0000, 4'b0000, "rel_low1");
    check_eq("rel_low_b", 64'(y_b), 64'd0);

    // Single edge held high for 5 cycles: exactly one pulse.
    cycle(4'b0001, 4'b0001, "single_rise");
    for (int i = 0; i < 4; i++) cycle(4'b0001, 4'b0000, "single_hold");
    cycle(4'b0000, 4'b0000, "single_fall");

    // Toggle every cycle: pulse on each rise, none on falls.
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0001, 4'b0001, "tog_rise");
      cycle(4'b0000, 4'b0000, "tog_fall");
    end

    // Independent lanes with simultaneous edges.
    cycle(4'b0000, 4'b0000, "ml_zero");
    cycle(4'b0101, 4'b0101, "ml_0101");
    cycle(4'b1111, 4'b1010, "ml_1111");
    cycle(4'b1111, 4'b0000, "ml_hold");
    cycle(4'b0000, 4'b0000, "ml_fall");

    // Glitch entirely between two edges is invisible.
    #2 d4 = 4'b1111;
    #2 d4 = 4'b0000;
    cycle(4'b0000, 4'b0000, "glitch");

    // Two-stage synchronizer: pulse on the 3rd edge after the change, one cycle wide.
    cycle(4'b0000, 4'b0000, "sync_pre");
    d4 = 4'b0001;
    tick();
    check_eq("sync_e1", 64'(y_b), 64'd0);
    tick();
    check_eq("sync_e2", 64'(y_b), 64'd0);
    tick();
    check_eq("sync_e3", 64'(y_b), 64'd1);
    tick();
    check_eq("sync_e4", 64'(y_b), 64'd0);
    cycle(4'b0000, 4'b0000, "sync_post");

    // Reset mid-pulse clears y at once; held-high input pulses again after release.
    cycle(4'b0001, 4'b0001, "mid_pulse");
    reset = 1'b0;
    #1;
    check_eq("mid_rst_a", 64'(y_a), 64'd0);
    check_eq("mid_rst_c", 64'(y_c), 64'd0);
    tick();
    check_eq("mid_rst_hold", 64'(y_a), 64'd0);
    reset = 1'b1;
    cycle(4'b0001, 4'b0001, "post_rst_high");
    cycle(4'b0001, 4'b0000, "post_rst_hold");
    cycle(4'b0000, 4'b0000, "post_rst_low");

`ifdef RISING_EDGE_COUNT_EN
    begin
      logic [3:0]  prev;
      logic [3:0]  dr;
      logic [3:0]  ey;
      logic [15:0] model_cnt;
      reset = 1'b0;
      d4    = 4'b0000;
      #1;
      check_eq("cnt_rst", 64'(cnt_a), 64'd0);
      tick();
      reset     = 1'b1;
      prev      = 4'b0000;
      model_cnt = 16'd0;
      for (int i = 0; i < 200; i++) begin
        dr = 4'($urandom);
        ey = dr & ~prev;
        prev = dr;
        if (ey != 4'b0000) model_cnt++;
        d4 = dr;
        tick();
        if (i % 20 == 0) check_eq("rnd_y", 64'(y_a), 64'(ey));
      end
      check_eq("rnd_cnt_a", 64'(cnt_a), 64'(model_cnt));
      check_eq("rnd_cnt_c", 64'(cnt_c), 64'(model_cnt));
      cycle(4'b0000, 4'b0000, "wrap_pre");
      force dut_a.count_q = 16'hffff;
      @(negedge clock);
      release dut_a.count_q;
      check_eq("wrap_preload", 64'(cnt_a), 64'hffff);
      cycle(4'b0010, 4'b0010, "wrap_pulse");
      check_eq("wrap_zero", 64'(cnt_a), 64'd0);
      cycle(4'b0000, 4'b0000, "wrap_fall");
      cycle(4'b0100, 4'b0100, "wrap_next");
      check_eq("wrap_one", 64'(cnt_a), 64'd1);
      reset = 1'b0;
      #1;
      check_eq("cnt_mid_rst", 64'(cnt_c), 64'd0);
      reset = 1'b1;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rising_edge.md
Name: rising_edge

Overview:
- Synchronous rising-edge detector. Emits a one-clock-cycle pulse on y for every 0->1 transition of d_in, as sampled on clock.
- Used as a front-end conditioner for level inputs that feed event-driven logic such as counters, FSM triggers and interrupt sources.
- Supports vector inputs, with one independent lane per bit.
- Has an optional input synchronizer for asynchronous sources.

Parameters:
- WIDTH, 1, number of independent detection lanes (bits of d_in and y); legal range 1..64.
- SYNC_STAGES, 0, flip-flop stages ahead of detection for metastability hardening; legal range 0..3; 0 = d_in is already synchronous to clock.
- REGISTERED_OUT, 1, 1 = y driven from a flop; 0 = y is combinational from the sampled/history flops.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- d_in  input  WIDTH  level input(s) to be monitored.
- y  output  WIDTH  per-lane rising-edge pulse, active-high, exactly one clock wide per edge.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (port name reset).
- While reset=0, asynchronously:
  - all synchronizer stages = 0;
  - history register d_q = 0;
  - y = 0.
- Release of reset is sampled on the next clock rising edge; no extra deassertion delay inside the block.
- Sampled input s:
  - SYNC_STAGES=0: s = d_in;
  - otherwise: s = the output of the last synchronizer flop (shift chain clocked by clock, stage 0 fed by d_in).
- Each clock edge: d_q <= s.
- Detect term per lane: e = s & ~d_q.
- REGISTERED_OUT=1:
  - y <= e at each clock edge;
  - y rises on the first clock edge that samples s=1 while d_q=0;
  - y stays high exactly one cycle.
- REGISTERED_OUT=0: y = d_q & ~d_q2, where d_q2 is a second history flop, so y is glitch-free and combinational only from flops.
- Latency from a d_in change to y high (REGISTERED_OUT=1): 1 + SYNC_STAGES clock edges.
- Boundary: an input held high produces one pulse only; y stays 0 until d_in returns to 0 for at least one sampled cycle.
- Boundary: an input toggling every cycle (0,1,0,1 sampled) gives a y pulse every second cycle.
- Boundary: a glitch shorter than one clock period between edges is not seen.
- Boundary: d_in=1 at the first edge after reset release produces a pulse, because history resets to 0.
- Boundary: reset asserted mid-pulse forces y=0 immediately; no pulse resumes after release unless a new 0->1 sample occurs (or the input is 1, per the rule above).
- Falling edges and steady levels never assert y.
- Lanes are fully independent; simultaneous edges on several lanes assert the corresponding y bits in the same cycle.

Optional Feature:
- Macro: RISING_EDGE_COUNT_EN.
- Defined:
  - adds output port edge_count [15:0], counting cycles in which any y bit is 1;
  - increments by 1 per such cycle, not per lane;
  - wraps 0xFFFF -> 0x0000;
  - reset (reset=0) clears it to 0;
  - updates on the same edge that y asserts, so it reads N after the N-th pulse cycle.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rising_edge_pkg:
  - constants MAX_WIDTH=64 and MAX_SYNC_STAGES=3;
  - COUNT_W=16 counter width constant.
- Parameter legality is checked with elaboration-time asserts against these constants.
- One natural sub-module, edge_sync:
  - parameterized WIDTH x SYNC_STAGES flop chain with async active-low clear;
  - pass-through when SYNC_STAGES=0.

Test Plan:
- Reset: hold reset=0 with d_in toggling for 3 cycles -> y=0 throughout. Release with d_in=0 -> y remains 0.
- Single edge (WIDTH=1, SYNC_STAGES=0): d_in 0->1, then held high for 5 cycles -> y=1 for exactly one cycle, on the first edge after d_in goes high; afterwards y=0.
- Toggle each cycle: d_in pattern 0,1,0,1,0,1 -> y pattern 0,1,0,1,0,1 one cycle later; no pulse on the falls.
- Synchronizer latency (SYNC_STAGES=2): single 0->1 -> y pulses on the 3rd clock edge after the change, width 1 cycle.
- Multi-lane (WIDTH=4): d_in 4'b0000 -> 4'b0101 -> 4'b1111 -> y=4'b0101, then y=4'b1010, then y=4'b0000.
- RISING_EDGE_COUNT_EN: random d_in for 200 cycles -> edge_count equals the bench-modeled count of y!=0 cycles. Preload 0xFFFF via 65536 pulses (or force) -> next pulse gives 0x0000. Reset mid-run -> edge_count is 0.
